// File: rtl/rca_pkg.sv
// Shared constants for the pipelined ripple-carry adder family and its consumers.
package rca_pkg;
    localparam int RCA_LAT   = 3;
    localparam int RCA_WIDTH = 4;

    // Sums carry one extra bit for the adder carry-out.
    function automatic int rca_sum_w(input int width);
        return width + 1;
    endfunction
endpackage

// File: rtl/rca_sum_fifo.sv
// First-word-fall-through FIFO with separate occupancy count and sticky drop flag.
module rca_sum_fifo #(
    parameter int DW    = 5,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          overflow
);
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          pop, push;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign rd_valid = !empty;
    assign pop      = rd_valid & rd_ready;
    // A read in the same cycle frees the slot, so a write into a full FIFO still lands.
    assign push     = wr_en & (!full | pop);
    assign rd_data  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (wr_en & !push) overflow <= 1'b1;
        end
    end
endmodule

// File: rtl/rca_sum_collector.sv
// Collects valid adder results into a FWFT FIFO behind a latency-matched valid delay line.
// Optional sum checker built when RCA_SUM_CHECK_EN is defined.
module rca_sum_collector
    import rca_pkg::*;
#(
    parameter int WIDTH = RCA_WIDTH,
    parameter int LAT   = RCA_LAT,
    parameter int DEPTH = 4,
    localparam int SW   = rca_sum_w(WIDTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [WIDTH-1:0] in_b_i,
    input  logic [SW-1:0]    sum_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [SW-1:0]    out_sum_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             overflow_o,
    output logic             err_o,
    output logic [7:0]       err_cnt_o
);
    logic [LAT-1:0] vld_pipe;
    logic           wr_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= in_valid_i;
            for (int i = 1; i < LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign wr_en = vld_pipe[LAT-1];

    rca_sum_fifo #(.DW(SW), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (sum_i),
        .rd_ready (out_ready_i),
        .rd_valid (out_valid_o),
        .rd_data  (out_sum_o),
        .count    (count_o),
        .full     (full_o),
        .empty    (empty_o),
        .overflow (overflow_o)
    );

`ifdef RCA_SUM_CHECK_EN
    logic [SW-1:0] ref_pipe [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) ref_pipe[i] <= '0;
            err_o     <= 1'b0;
            err_cnt_o <= '0;
        end else begin
            ref_pipe[0] <= SW'(in_a_i) + SW'(in_b_i);
            for (int i = 1; i < LAT; i++) ref_pipe[i] <= ref_pipe[i-1];
            // Checked even when the FIFO drops the write.
            err_o <= wr_en && (ref_pipe[LAT-1] != sum_i);
            if (wr_en && (ref_pipe[LAT-1] != sum_i) && (err_cnt_o != 8'hff))
                err_cnt_o <= err_cnt_o + 8'd1;
        end
    end
`else
    logic unused_operands;
    assign unused_operands = ^{in_a_i, in_b_i};
    assign err_o     = 1'b0;
    assign err_cnt_o = '0;
`endif
endmodule

// File: tb/tb_rca_sum_collector.sv
// Randomized bench for rca_sum_collector against a queue-based model of adder + FIFO.
module tb_rca_sum_collector;
    localparam int WIDTH = 4;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;
    localparam int SW    = WIDTH + 1;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid_i = 1'b0;
    logic [WIDTH-1:0] in_a_i = '0, in_b_i = '0;
    logic [SW-1:0]    sum_i = '0;
    logic             out_valid_o, out_ready_i = 1'b0;
    logic [SW-1:0]    out_sum_o;
    logic [CW-1:0]    count_o;
    logic             full_o, empty_o, overflow_o, err_o;
    logic [7:0]       err_cnt_o;

    rca_sum_collector #(.WIDTH(WIDTH), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_a_i(in_a_i), .in_b_i(in_b_i),
        .sum_i(sum_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_sum_o(out_sum_o), .count_o(count_o), .full_o(full_o), .empty_o(empty_o),
        .overflow_o(overflow_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Model: adder in flight (valid, driven sum, true sum) and FIFO contents.
    bit          m_v  [$];
    logic [SW-1:0] m_s [$];
    logic [SW-1:0] m_t [$];
    logic [SW-1:0] m_q [$];
    bit          m_ovf = 0;
    bit          m_err = 0;
    int          m_ecnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_v.delete(); m_s.delete(); m_t.delete(); m_q.delete();
        for (int i = 0; i < LAT; i++) begin
            m_v.push_back(0); m_s.push_back('0); m_t.push_back('0);
        end
        m_ovf = 0; m_err = 0; m_ecnt = 0;
    endtask

    // One clock cycle: check current outputs, drive this cycle's inputs, advance the model.
    task automatic step(input bit v, input int a, input int b, input bit rdy,
                        input bit corrupt, input bit do_rst);
        logic [SW-1:0] tru, drv;
        bit wr, rd, mis;
        @(negedge clk);
        chk("valid", out_valid_o, m_q.size() != 0);
        if (m_q.size() != 0) chk("sum", out_sum_o, m_q[0]);
        chk("count", count_o, m_q.size());
        chk("full", full_o, m_q.size() == DEPTH);
        chk("empty", empty_o, m_q.size() == 0);
        chk("overflow", overflow_o, m_ovf);
        chk("err", err_o, m_err);
        chk("err_cnt", err_cnt_o, m_ecnt);

        tru = SW'(a) + SW'(b);
        drv = corrupt ? tru + SW'(1) : tru;
        rst         = do_rst;
        in_valid_i  = v;
        in_a_i      = WIDTH'(a);
        in_b_i      = WIDTH'(b);
        out_ready_i = rdy;
        // Adder output now is what was presented LAT cycles ago; garbage when idle.
        sum_i = m_v[0] ? m_s[0] : SW'($urandom);

        if (do_rst) begin
            model_clear();
            return;
        end
        wr  = m_v[0];
        mis = wr && (sum_i != m_t[0]);
        rd  = (m_q.size() != 0) && rdy;
        if (rd) void'(m_q.pop_front());
        if (wr) begin
            if (m_q.size() < DEPTH) m_q.push_back(sum_i);
            else m_ovf = 1;
        end
`ifdef RCA_SUM_CHECK_EN
        m_err = mis;
        if (mis && m_ecnt < 255) m_ecnt++;
`else
        m_err = 0;
        if (mis) m_ecnt = 0;
`endif
        void'(m_v.pop_front()); void'(m_s.pop_front()); void'(m_t.pop_front());
        m_v.push_back(v); m_s.push_back(drv); m_t.push_back(tru);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, 0, rdy, 0, 0);
    endtask

    initial begin
        model_clear();
        // Reset state
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
        idle(1, 0);

        // Single result: 5 + 6, visible LAT+1 cycles later
        step(1, 5, 6, 0, 0, 0);
        idle(3, 0);
        step(0, 0, 0, 1, 0, 0);
        chk("single_sum", out_sum_o, 11);
        chk("single_count", count_o, 1);
        idle(2, 0);

        // Carry-out preserved
        step(1, 15, 15, 0, 0, 0);
        idle(4, 0);
        chk("carry_sum", out_sum_o, 30);
        idle(2, 1);

        // Fill past capacity: fifth result dropped
        for (int k = 1; k <= 5; k++) step(1, k, 0, 0, 0, 0);
        idle(LAT + 1, 0);
        chk("fill_full", full_o, 1);
        chk("fill_ovf", overflow_o, 1);
        chk("fill_head", out_sum_o, 1);
        idle(6, 1);
        chk("ovf_sticky", overflow_o, 1);

        // Full with simultaneous read and write
        step(0, 0, 0, 0, 0, 1);
        for (int k = 1; k <= 4; k++) step(1, k, 0, 0, 0, 0);
        step(1, 9, 0, 0, 0, 0);
        idle(LAT - 1, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("rw_full_count", count_o, 4);
        chk("rw_full_ovf", overflow_o, 0);
        idle(6, 1);

        // Reset with results in flight
        step(1, 2, 3, 0, 0, 0);
        step(1, 4, 5, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        idle(LAT + 2, 0);
        chk("midrst_empty", empty_o, 1);

        // Random traffic, occasional corrupted sums
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 199) == 0);

`ifdef RCA_SUM_CHECK_EN
        step(0, 0, 0, 1, 0, 1);
        step(1, 3, 4, 1, 1, 0);
        idle(LAT + 1, 1);
        for (int i = 0; i < 300; i++) step(1, 3, 4, 1, 1, 0);
        idle(LAT + 2, 1);
        chk("err_sat", err_cnt_o, 255);
`endif
        idle(LAT + 2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
